// File: rtl/ls_pat_gen.sv
// Serial test-pattern generator with a delay-aligned reference stream for the chain checker.
// Optional feature: define ERR_INJ_EN to add INJ_ERR / INJ_CNT single-bit error injection.
module ls_pat_gen #(
  parameter int PRE_LEN = 16,
  parameter int DLY_W   = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       MODE,
  input  logic [DLY_W-1:0] REF_DLY,
  input  logic [31:0]      LEN,
`ifdef ERR_INJ_EN
  input  logic             INJ_ERR,
  output logic [15:0]      INJ_CNT,
`endif
  output logic             PAT_OUT,
  output logic             RPG_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [31:0]      BIT_CNT
);

  localparam int DEPTH = 2**DLY_W;
  localparam int PC_W  = $clog2(PRE_LEN);

  // state  | meaning
  // S_IDLE | waiting for START, PAT_OUT held low
  // S_PRE  | zero preamble, PRE_LEN cycles
  // S_RUN  | pattern bits, first one is the sync '1'
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       bit_cnt_q, bit_cnt_d;
  logic [PC_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [14:0]       lfsr_q, lfsr_d;
  logic [2:0]        phase_q, phase_d;
  logic              pat_q, pat_d;
  logic              rpg_q, rpg_d;
  logic              done_q, done_d;
  logic [DEPTH-1:0]  dline_q, dline_d;
  logic              pat_true_d;
  logic              cur_bit;
  logic              start_go, run_go, last_bit, inj;

  assign start_go = (state_q == S_IDLE) && START && !STOP;
  assign run_go   = (state_q == S_RUN) && !STOP;
  assign last_bit = (len_q != 32'd0) && (bit_cnt_q + 32'd1 == len_q);

`ifdef ERR_INJ_EN
  logic [15:0] inj_cnt_q, inj_cnt_d;

  assign inj = run_go & INJ_ERR;

  always_comb begin
    inj_cnt_d = inj_cnt_q;
    if (inj && inj_cnt_q != 16'hFFFF) inj_cnt_d = inj_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) inj_cnt_q <= 16'd0;
    else        inj_cnt_q <= inj_cnt_d;
  end

  assign INJ_CNT = inj_cnt_q;
`else
  assign inj = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_go) state_d = S_PRE;
      S_PRE: begin
        if (STOP) state_d = S_IDLE;
        else if (pre_cnt_q == PC_W'(PRE_LEN - 1)) state_d = S_RUN;
      end
      S_RUN: if (STOP || last_bit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (mode_q)
      2'd0:    cur_bit = ~phase_q[0];
      2'd1:    cur_bit = lfsr_q[6];
      2'd2:    cur_bit = lfsr_q[14];
      default: cur_bit = (phase_q == 3'd0);
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    dly_d      = dly_q;
    len_d      = len_q;
    bit_cnt_d  = bit_cnt_q;
    pre_cnt_d  = pre_cnt_q;
    lfsr_d     = lfsr_q;
    phase_d    = phase_q;
    done_d     = done_q;
    pat_true_d = 1'b0;
    if (start_go) begin
      mode_d    = MODE;
      dly_d     = REF_DLY;
      len_d     = LEN;
      done_d    = 1'b0;
      bit_cnt_d = 32'd0;
      pre_cnt_d = '0;
      lfsr_d    = '1;
      phase_d   = 3'd0;
    end
    if (state_q == S_PRE) pre_cnt_d = pre_cnt_q + PC_W'(1);
    if (run_go) begin
      pat_true_d = cur_bit;
      bit_cnt_d  = bit_cnt_q + 32'd1;
      phase_d    = phase_q + 3'd1;
      if (mode_q == 2'd1) lfsr_d[6:0] = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      if (mode_q == 2'd2) lfsr_d      = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
      if (last_bit) done_d = 1'b1;
    end
    // Reference history holds the uninverted bit; tap 0 is the value PAT_OUT is about to take.
    pat_d   = pat_true_d ^ inj;
    dline_d = {dline_q[DEPTH-2:0], pat_true_d};
    rpg_d   = dline_d[dly_d];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q    <= 2'd0;
      dly_q     <= '0;
      len_q     <= 32'd0;
      bit_cnt_q <= 32'd0;
      pre_cnt_q <= '0;
      lfsr_q    <= '1;
      phase_q   <= 3'd0;
      pat_q     <= 1'b0;
      rpg_q     <= 1'b0;
      done_q    <= 1'b0;
      dline_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      dly_q     <= dly_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      lfsr_q    <= lfsr_d;
      phase_q   <= phase_d;
      pat_q     <= pat_d;
      rpg_q     <= rpg_d;
      done_q    <= done_d;
      dline_q   <= dline_d;
    end
  end

  always_comb begin
    BUSY    = (state_q != S_IDLE);
    PAT_OUT = pat_q;
    RPG_OUT = rpg_q;
    DONE    = done_q;
    BIT_CNT = bit_cnt_q;
  end

endmodule

// File: tb/tb_ls_pat_gen.sv
// Scoreboard bench for ls_pat_gen: stimulus queues per-cycle expected PAT/RPG, a monitor compares.
module tb_ls_pat_gen;
  localparam int PRE = 16;
  localparam int DW  = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic [1:0]    MODE = 2'd0;
  logic [DW-1:0] REF_DLY = '0;
  logic [31:0]   LEN = 32'd0;
  logic          PAT_OUT, RPG_OUT, BUSY, DONE;
  logic [31:0]   BIT_CNT;
`ifdef ERR_INJ_EN
  logic          INJ_ERR = 1'b0;
  logic [15:0]   INJ_CNT;
`endif

  ls_pat_gen #(.PRE_LEN(PRE), .DLY_W(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .MODE(MODE),
    .REF_DLY(REF_DLY), .LEN(LEN),
`ifdef ERR_INJ_EN
    .INJ_ERR(INJ_ERR), .INJ_CNT(INJ_CNT),
`endif
    .PAT_OUT(PAT_OUT), .RPG_OUT(RPG_OUT), .BUSY(BUSY), .DONE(DONE), .BIT_CNT(BIT_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {int c; logic pat; logic rpg;} exp_t;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   t0 = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: the DUT presents one PAT/RPG pair per cycle; compare against the entry for this cycle.
  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      if (e.c < cyc) chk("sb_stale", 32'(cyc), 32'(e.c));
      else begin
        chk($sformatf("pat@%0d", e.c - t0), {31'd0, PAT_OUT}, {31'd0, e.pat});
        chk($sformatf("rpg@%0d", e.c - t0), {31'd0, RPG_OUT}, {31'd0, e.rpg});
      end
    end
  end

  // Issues START and queues the expected streams; inj is the data-bit index to invert (-1 none).
  task automatic run_burst(input logic [1:0] m, input int d, input int len, input int nb,
                           input int inj);
    logic        b[];
    logic        t[];
    logic [14:0] l;
    int          tot;
    tot = PRE + nb + ((len != 0) ? d + 3 : 0);
    b = new[nb];
    l = '1;
    for (int i = 0; i < nb; i++) begin
      case (m)
        2'd0: b[i] = (i % 2 == 0);
        2'd1: begin b[i] = l[6];  l[6:0] = {l[5:0], l[6] ^ l[5]}; end
        2'd2: begin b[i] = l[14]; l = {l[13:0], l[14] ^ l[13]}; end
        default: b[i] = (i % 8 == 0);
      endcase
    end
    t = new[tot + 1];
    for (int k = 0; k <= tot; k++)
      t[k] = (k > PRE && k <= PRE + nb) ? b[k - PRE - 1] : 1'b0;
    @(posedge CLK); #1;
    MODE = m; REF_DLY = d[DW-1:0]; LEN = len; START = 1'b1;
    t0 = cyc + 1;
    for (int k = 1; k <= tot; k++)
      sb.push_back(exp_t'{t0 + k, t[k] ^ (inj >= 0 && k == PRE + 1 + inj),
                          (k > d) ? t[k - d] : 1'b0});
    @(posedge CLK); #1;
    START = 1'b0;
    chk("start_busy", {31'd0, BUSY}, 32'd1);
    chk("start_done_clr", {31'd0, DONE}, 32'd0);
    chk("start_cnt_clr", BIT_CNT, 32'd0);
    MODE = ~MODE; REF_DLY = ~REF_DLY; LEN = 32'd3;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  initial begin
    int s;
    #2;
    chk("rst_pat", {31'd0, PAT_OUT}, 32'd0);
    chk("rst_rpg", {31'd0, RPG_OUT}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_cnt", BIT_CNT, 32'd0);
    #10 RST_N = 1'b1;
    repeat (3) @(posedge CLK);

    // checkerboard, counted, no reference delay
    run_burst(2'd0, 0, 8, 8, -1);
    wait_drain();
    chk("t1_done", {31'd0, DONE}, 32'd1);
    chk("t1_cnt", BIT_CNT, 32'd8);
    chk("t1_busy", {31'd0, BUSY}, 32'd0);

    // PRBS7 continuous, then STOP
    run_burst(2'd1, 2, 0, 1127, -1);
    wait_drain();
    chk("t2_busy_run", {31'd0, BUSY}, 32'd1);
    STOP = 1'b1;
    s = cyc + 1;
    @(posedge CLK); #1;
    STOP = 1'b0;
    chk("t2_stop_pat", {31'd0, PAT_OUT}, 32'd0);
    chk("t2_stop_busy", {31'd0, BUSY}, 32'd0);
    chk("t2_stop_done", {31'd0, DONE}, 32'd0);
    chk("t2_stop_cnt", BIT_CNT, 32'(s - 1 - t0 - PRE));
    repeat (20) @(posedge CLK);

    // walking-one with a 5-cycle reference delay; tail drains on RPG_OUT
    run_burst(2'd3, 5, 24, 24, -1);
    wait_drain();
    chk("t3_done", {31'd0, DONE}, 32'd1);
    chk("t3_cnt", BIT_CNT, 32'd24);
    chk("t3_rpg_drained", {31'd0, RPG_OUT}, 32'd0);

    // START while running is ignored; START+STOP in IDLE stays IDLE
    run_burst(2'd0, 0, 200, 200, -1);
    wait_cyc(t0 + PRE + 100);
    chk("t4_cnt100", BIT_CNT, 32'd100);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("t4_busy_kept", {31'd0, BUSY}, 32'd1);
    chk("t4_no_restart", BIT_CNT, 32'd101);
    wait_drain();
    chk("t4_done", {31'd0, DONE}, 32'd1);
    chk("t4_cnt", BIT_CNT, 32'd200);
    START = 1'b1; STOP = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; STOP = 1'b0;
    chk("t4_ss_busy", {31'd0, BUSY}, 32'd0);
    chk("t4_ss_done", {31'd0, DONE}, 32'd1);
    chk("t4_ss_cnt", BIT_CNT, 32'd200);
    repeat (5) @(posedge CLK);

    // asynchronous reset mid-run, then PRBS15 replays from the seed
    run_burst(2'd2, 3, 0, 60, -1);
    wait_cyc(t0 + PRE + 30);
    #1;
    sb.delete();
    RST_N = 1'b0;
    #1;
    chk("t5_rst_pat", {31'd0, PAT_OUT}, 32'd0);
    chk("t5_rst_rpg", {31'd0, RPG_OUT}, 32'd0);
    chk("t5_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("t5_rst_cnt", BIT_CNT, 32'd0);
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    run_burst(2'd2, 3, 40, 40, -1);
    wait_drain();
    chk("t5_done", {31'd0, DONE}, 32'd1);
    chk("t5_cnt", BIT_CNT, 32'd40);

`ifdef ERR_INJ_EN
    repeat (5) @(posedge CLK);
    run_burst(2'd0, 0, 8, 8, 3);
    wait_cyc(t0 + PRE + 3);
    INJ_ERR = 1'b1;
    @(posedge CLK); #1;
    INJ_ERR = 1'b0;
    wait_drain();
    chk("t6_inj_cnt", {16'd0, INJ_CNT}, 32'd1);
    chk("t6_done", {31'd0, DONE}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
